wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
// - Round-robin arbiter that shares one Wishbone slave port between two Wishbone masters.
// - Typical masters: LM32 instruction and data buses; a future DMA engine is a second use.
// - Sits between the masters and conbus, or in front of a single shared slave (bram, sram).
// - Adds a stuck-cycle watchdog: a slave that never acks produces a bus error.
// PARAMETERS
// - adr_width     32   address width of all ports
// - dat_width     32   data width; sel width = dat_width/8
// - timeout       255  stb-without-ack cycles before err is issued; 0 disables the watchdog
// - fixed_prio    0    1 = m0 always wins a tie; 0 = round-robin on ties
// PORTS
// - clk            in   1           system clock; all state on rising edge
// - rst            in   1           asynchronous reset, active-low
// - m0_adr_i       in   adr_width   master 0 address
// - m0_dat_i       in   dat_width   master 0 write data
// - m0_dat_o       out  dat_width   master 0 read data
// - m0_sel_i       in   dat_width/8 master 0 byte select
// - m0_we_i        in   1           master 0 write enable
// - m0_cyc_i       in   1           master 0 cycle
// - m0_stb_i       in   1           master 0 strobe
// - m0_ack_o       out  1           master 0 ack
// - m0_err_o       out  1           master 0 error
// - m1_*           same set as m0_* for master 1
// - s_adr_o        out  adr_width   slave address
// - s_dat_o        out  dat_width   slave write data
// - s_dat_i        in   dat_width   slave read data
// - s_sel_o        out  dat_width/8 slave byte select
// - s_we_o         out  1           slave write enable
// - s_cyc_o        out  1           slave cycle
// - s_stb_o        out  1           slave strobe
// - s_ack_i        in   1           slave ack
// - gnt_o          out  2           one-hot grant, for debug/LED; 2'b00 when idle
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, last_gnt=1 (so m0 wins the first tie), wdog=0.
//   All outputs 0 immediately, including any cycle in flight.
// - FSM has three states: IDLE, OWN0, OWN1. Grant is registered.
// - IDLE: only m0_cyc -> OWN0; only m1_cyc -> OWN1.
// - IDLE with both cyc: fixed_prio=1 -> OWN0; otherwise the master that is not last_gnt.
// - OWNx: ownership is held while mx_cyc_i=1; this covers LOCK and burst sequences.
// - OWNx exit on mx_cyc_i=0. If the other master requests in that same cycle, go directly to OWNy;
//   otherwise go to IDLE. last_gnt is updated on every grant.
// - Latency: cyc asserted in IDLE -> s_cyc_o/s_stb_o asserted on the next cycle.
//   Handover OWNx->OWNy takes 1 cycle, with no idle gap.
// - Slave outputs in OWNx: adr/dat/sel/we/stb come from mx, combinationally; s_cyc_o=1.
//   In IDLE: all slave outputs are 0.
// - Master outputs: mx_dat_o = s_dat_i when owned, else 0.
//   mx_ack_o = s_ack_i & owned(x) & ~err_pulse.
// - A non-owner never sees ack/err; its requests stall until granted.
// - Watchdog: wdog increments each cycle that s_stb_o=1 and s_ack_i=0.
//   It clears on ack, on a grant change, or when cyc drops.
// - Watchdog expiry (wdog==timeout-1, timeout!=0): registered 1-cycle err_pulse to the owner.
//   During err_pulse s_stb_o is forced 0 and wdog clears. Ownership is kept until the owner drops cyc.
// - An ack arriving in the same cycle as expiry wins: ack is delivered, no err.
// - mx_cyc_i dropping mid-transfer aborts the transfer: the grant releases on the next edge.
//   A late s_ack_i is ignored.
// - Widths: wdog is $clog2(timeout+1) bits and saturates. There is no wrap-around.
// STRUCTURE
// - Shared include wb_defs.vh: state encodings ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
//   Also the WB_SEL_W(dw) macro.
// - One sub-module, wb_arb_wdog: counter, compare, err_pulse register.
//   Inputs: clk, rst, run, clr. Output: expire.
// - The top holds the FSM, last_gnt register and the combinational mux.
// TESTING
// - After reset, m0 single read, slave acks after 2 cycles
//   -> s_stb_o rises 1 cycle after m0_cyc; m0_ack_o=1 carrying s_dat_i=32'hDEADBEEF; gnt_o=01.
// - m0 and m1 assert cyc in the same cycle, fixed_prio=0 -> m0 granted first.
//   When m0 drops cyc, gnt_o goes 01->10 in 1 cycle; the next tie goes to m0 again.
// - m1 holds cyc across 4 back-to-back acked strobes while m0 requests
//   -> gnt_o stays 10 for all 4; m0_ack_o never asserts.
// - timeout=8, slave never acks -> m0_err_o=1 for exactly 1 cycle, 8 cycles after stb.
//   s_stb_o=0 in that cycle; m0_ack_o stays 0.
// - s_ack_i in the same cycle as watchdog expiry -> ack delivered, err=0.
// - Async rst=0 mid-transfer (OWN1) -> all outputs 0 without a clock edge.
//   After release, a tie grants m0.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// wb_rr_arbiter_pkg: FSM encodings and sizing helpers shared by the arbiter files
package wb_rr_arbiter_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    function automatic int wdog_w(input int t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

    function automatic int sel_w(input int dw);
        return dw / 8;
    endfunction
endpackage

// File: rtl/wb_arb_wdog.sv
// wb_arb_wdog: stuck-strobe counter that raises a registered one-cycle expire pulse
module wb_arb_wdog
    import wb_rr_arbiter_pkg::*;
#(
    parameter int timeout = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);
    localparam int W = wdog_w(timeout);
    localparam logic [W-1:0] LIM = W'((timeout == 0) ? 0 : timeout - 1);
    logic [W-1:0] cnt;
    logic hit;
    // a clear in the expiry cycle means ack or grant change, which must win over err
    assign hit = (timeout != 0) && run && !clr && (cnt == LIM);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            expire <= 1'b0;
        end else begin
            expire <= hit;
            cnt <= (clr || hit || expire) ? '0 : (run && cnt != '1) ? cnt + 1'b1 : cnt;
        end
    end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master Wishbone round-robin arbiter with a stuck-cycle watchdog
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int adr_width  = 32,
    parameter int dat_width  = 32,
    parameter int timeout    = 255,
    parameter int fixed_prio = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [adr_width-1:0]   m0_adr_i,
    input  logic [dat_width-1:0]   m0_dat_i,
    output logic [dat_width-1:0]   m0_dat_o,
    input  logic [dat_width/8-1:0] m0_sel_i,
    input  logic                   m0_we_i,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,
    input  logic [adr_width-1:0]   m1_adr_i,
    input  logic [dat_width-1:0]   m1_dat_i,
    output logic [dat_width-1:0]   m1_dat_o,
    input  logic [dat_width/8-1:0] m1_sel_i,
    input  logic                   m1_we_i,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,
    output logic [adr_width-1:0]   s_adr_o,
    output logic [dat_width-1:0]   s_dat_o,
    input  logic [dat_width-1:0]   s_dat_i,
    output logic [dat_width/8-1:0] s_sel_o,
    output logic                   s_we_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    input  logic                   s_ack_i,
    output logic [1:0]             gnt_o
);
    logic [1:0] state, nxt;
    logic last_gnt, err_pulse, own0, own1, tie_m0, own_cyc, run, clr;
    assign own0 = (state == ST_OWN0);
    assign own1 = (state == ST_OWN1);
    // last_gnt=1 means m1 was served last, so m0 takes the next tie
    assign tie_m0 = (fixed_prio != 0) || last_gnt;
    always_comb begin
        nxt = own0 ? (m0_cyc_i ? ST_OWN0 : m1_cyc_i ? ST_OWN1 : ST_IDLE)
            : own1 ? (m1_cyc_i ? ST_OWN1 : m0_cyc_i ? ST_OWN0 : ST_IDLE)
            : (m0_cyc_i && (!m1_cyc_i || tie_m0)) ? ST_OWN0
            : m1_cyc_i ? ST_OWN1 : ST_IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= nxt;
            last_gnt <= (nxt == ST_OWN1) ? 1'b1 : (nxt == ST_OWN0) ? 1'b0 : last_gnt;
        end
    end
    assign s_adr_o = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
    assign s_dat_o = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
    assign s_sel_o = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
    assign s_we_o  = own0 ? m0_we_i : own1 & m1_we_i;
    assign s_cyc_o = own0 | own1;
    assign s_stb_o = (own0 ? m0_stb_i : own1 & m1_stb_i) & ~err_pulse;
    assign gnt_o   = {own1, own0};
    assign own_cyc = own0 ? m0_cyc_i : own1 & m1_cyc_i;
    assign run = s_stb_o & ~s_ack_i;
    assign clr = s_ack_i | (nxt != state) | ~own_cyc;
    wb_arb_wdog #(.timeout(timeout)) u_wdog (
        .clk(clk),
        .rst(rst),
        .run(run),
        .clr(clr),
        .expire(err_pulse)
    );
    assign m0_dat_o = own0 ? s_dat_i : '0;
    assign m1_dat_o = own1 ? s_dat_i : '0;
    assign m0_ack_o = s_ack_i & own0 & ~err_pulse;
    assign m1_ack_o = s_ack_i & own1 & ~err_pulse;
    assign m0_err_o = err_pulse & own0;
    assign m1_err_o = err_pulse & own1;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenario tests for the two-master arbiter (timeout=8)
module tb_wb_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]  gnt_o;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.adr_width(32), .dat_width(32), .timeout(8), .fixed_prio(0)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    task automatic idle_inputs;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_ack_i = 0; s_dat_i = '0;
    endtask

    task automatic do_reset;
        rst = 0;
        idle_inputs();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: gnt_o=%b expected 00", gnt_o); end
        checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin errors++; $display("FAIL reset_slave: cyc/stb=%b expected 00", {s_cyc_o, s_stb_o}); end
        rst = 1;
        @(negedge clk);
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_idle: gnt_o=%b expected 00", gnt_o); end
    endtask

    task automatic test_single_read;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100; m0_sel_i = 4'hf;
        #1;
        checks++; if (s_stb_o !== 1'b0) begin errors++; $display("FAIL read_latency: s_stb_o=%b expected 0", s_stb_o); end
        @(negedge clk); #1;
        checks++; if (s_stb_o !== 1'b1) begin errors++; $display("FAIL read_stb: s_stb_o=%b expected 1", s_stb_o); end
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL read_gnt: gnt_o=%b expected 01", gnt_o); end
        checks++; if (s_adr_o !== 32'h100) begin errors++; $display("FAIL read_adr: s_adr_o=%h expected 00000100", s_adr_o); end
        @(negedge clk); #1;
        checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL read_noack: m0_ack_o=%b expected 0", m0_ack_o); end
        @(negedge clk);
        s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
        #1;
        checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL read_ack: m0_ack_o=%b expected 1", m0_ack_o); end
        checks++; if (m0_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL read_dat: m0_dat_o=%h expected deadbeef", m0_dat_o); end
        checks++; if ({m1_ack_o, m1_dat_o} !== 33'h0) begin errors++; $display("FAIL read_m1_quiet: m1 ack/dat=%h expected 0", {m1_ack_o, m1_dat_o}); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk); #1;
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL read_release: gnt_o=%b expected 00", gnt_o); end
    endtask

    task automatic test_tie;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hA0;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hA1; m1_we_i = 1;
        @(negedge clk); #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL tie_first: gnt_o=%b expected 01", gnt_o); end
        checks++; if (s_adr_o !== 32'hA0) begin errors++; $display("FAIL tie_adr0: s_adr_o=%h expected 000000a0", s_adr_o); end
        m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge clk); #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL tie_handover: gnt_o=%b expected 10", gnt_o); end
        checks++; if ({s_cyc_o, s_we_o, s_adr_o} !== {2'b11, 32'hA1}) begin errors++; $display("FAIL tie_slave1: cyc=%b we=%b adr=%h expected 1 1 000000a1", s_cyc_o, s_we_o, s_adr_o); end
        m1_cyc_i = 0; m1_stb_i = 0;
        @(negedge clk); #1;
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL tie_idle: gnt_o=%b expected 00", gnt_o); end
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        @(negedge clk); #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL tie_second: gnt_o=%b expected 01", gnt_o); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hB0;
        @(negedge clk);
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
            s_dat_i = 32'h100 + i;
            #1;
            checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL b2b_gnt%0d: gnt_o=%b expected 10", i, gnt_o); end
            checks++; if ({m1_ack_o, m0_ack_o} !== 2'b10) begin errors++; $display("FAIL b2b_ack%0d: m1/m0 ack=%b expected 10", i, {m1_ack_o, m0_ack_o}); end
            checks++; if (m1_dat_o !== 32'h100 + i) begin errors++; $display("FAIL b2b_dat%0d: m1_dat_o=%h expected %h", i, m1_dat_o, 32'h100 + i); end
            @(negedge clk);
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        @(negedge clk); #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL b2b_to_m0: gnt_o=%b expected 01", gnt_o); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_timeout;
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if ({s_stb_o, m0_err_o} !== 2'b10) begin errors++; $display("FAIL wdog_wait%0d: stb/err=%b expected 10", i, {s_stb_o, m0_err_o}); end
            @(negedge clk);
        end
        #1;
        checks++; if (m0_err_o !== 1'b1) begin errors++; $display("FAIL wdog_err: m0_err_o=%b expected 1", m0_err_o); end
        checks++; if ({s_stb_o, m0_ack_o, m1_err_o} !== 3'b000) begin errors++; $display("FAIL wdog_stb_low: stb/ack/m1err=%b expected 000", {s_stb_o, m0_ack_o, m1_err_o}); end
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL wdog_keep: gnt_o=%b expected 01", gnt_o); end
        @(negedge clk); #1;
        checks++; if ({s_stb_o, m0_err_o} !== 2'b10) begin errors++; $display("FAIL wdog_one_cycle: stb/err=%b expected 10", {s_stb_o, m0_err_o}); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_ack_at_expiry;
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        repeat (7) @(negedge clk);
        s_ack_i = 1; s_dat_i = 32'h5A5A5A5A;
        #1;
        checks++; if ({m0_ack_o, m0_err_o} !== 2'b10) begin errors++; $display("FAIL race_ack: ack/err=%b expected 10", {m0_ack_o, m0_err_o}); end
        @(negedge clk);
        s_ack_i = 0;
        #1;
        checks++; if ({s_stb_o, m0_err_o} !== 2'b10) begin errors++; $display("FAIL race_no_err: stb/err=%b expected 10", {s_stb_o, m0_err_o}); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_abort;
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge clk);
        s_ack_i = 1;
        #1;
        checks++; if ({gnt_o, m0_ack_o} !== 3'b000) begin errors++; $display("FAIL abort_late_ack: gnt/ack=%b expected 000", {gnt_o, m0_ack_o}); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hC0;
        @(negedge clk);
        s_ack_i = 1; s_dat_i = 32'h55;
        #1;
        checks++; if ({gnt_o, m1_ack_o} !== 3'b101) begin errors++; $display("FAIL arst_pre: gnt/ack=%b expected 101", {gnt_o, m1_ack_o}); end
        rst = 0;
        #1;
        checks++; if ({gnt_o, s_cyc_o, s_stb_o, m1_ack_o} !== 5'b0) begin errors++; $display("FAIL arst_ctrl: gnt/cyc/stb/ack=%b expected 00000", {gnt_o, s_cyc_o, s_stb_o, m1_ack_o}); end
        checks++; if ({s_adr_o, m1_dat_o} !== 64'h0) begin errors++; $display("FAIL arst_data: adr=%h dat=%h expected 0", s_adr_o, m1_dat_o); end
        s_ack_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        rst = 1;
        @(negedge clk); #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL arst_tie: gnt_o=%b expected 01", gnt_o); end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_ack_at_expiry();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
